// File: rtl/input_conditioner_if.sv
// Purpose: bundles the raw board inputs and the conditioned button/switch outputs of input_conditioner.
// Latency: none, wiring only.
// Backpressure: none; every signal is a free-running level or pulse.
//
// Ports (signals):
//   button, freq_set_raw[1:0], dir_set_raw       raw asynchronous board inputs
//   btn_level, btn_press, btn_long, btn_release  debounced button level and one-cycle event pulses
//   freq_set[1:0], dir_set                       debounced switch values
// Modports: master = board/stimulus side, slave = conditioner side.
interface input_conditioner_if;
    logic       button;
    logic [1:0] freq_set_raw;
    logic       dir_set_raw;

    logic       btn_level;
    logic       btn_press;
    logic       btn_long;
    logic       btn_release;
    logic [1:0] freq_set;
    logic       dir_set;

    modport master (
        output button, freq_set_raw, dir_set_raw,
        input  btn_level, btn_press, btn_long, btn_release, freq_set, dir_set
    );

    modport slave (
        input  button, freq_set_raw, dir_set_raw,
        output btn_level, btn_press, btn_long, btn_release, freq_set, dir_set
    );
endinterface

// File: rtl/input_conditioner.sv
// Purpose: synchronise and debounce the push-button and slide switches; emit press/long/release pulses.
// Latency: press/release pulses DEBOUNCE_CYCLES+2 cycles after a clean edge; switches SW_STABLE_CYCLES+2.
// Backpressure: none; outputs are free-running registered levels and one-cycle pulses.
//
// Ports:
//   clk  - the only clock
//   rst  - synchronous, active-high reset; clears every output, counter and synchroniser flop
//   io   - input_conditioner_if.slave: raw button/freq_set_raw/dir_set_raw in;
//          btn_level, btn_press, btn_long, btn_release, freq_set, dir_set out
// Parameters: DEBOUNCE_CYCLES >= 2, LONG_CYCLES > DEBOUNCE_CYCLES, SW_STABLE_CYCLES >= 2.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES  = 2000000,
    parameter int LONG_CYCLES      = 100000000,
    parameter int SW_STABLE_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               rst,
    input_conditioner_if.slave io
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam int SW_W   = $clog2(SW_STABLE_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(SW_STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        LONG_HELD,
        DB_RELEASE
    } state_t;

    // ---------------- 2-flop synchronisers ----------------
    logic       btn_s1, btn_sync;
    logic [1:0] freq_s1, freq_sync;
    logic       dir_s1, dir_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1    <= 1'b0;
            btn_sync  <= 1'b0;
            freq_s1   <= 2'b00;
            freq_sync <= 2'b00;
            dir_s1    <= 1'b0;
            dir_sync  <= 1'b0;
        end else begin
            btn_s1    <= io.button;
            btn_sync  <= btn_s1;
            freq_s1   <= io.freq_set_raw;
            freq_sync <= freq_s1;
            dir_s1    <= io.dir_set_raw;
            dir_sync  <= dir_s1;
        end
    end

    // ---------------- button FSM ----------------
    state_t              state, state_nxt;
    logic [DB_W-1:0]     db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic                long_flag, long_flag_nxt;
    logic                level_q, level_nxt;
    logic                press_q, press_nxt;
    logic                long_q, long_nxt;
    logic                release_q, release_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_flag <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            long_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            long_flag <= long_flag_nxt;
            level_q   <= level_nxt;
            press_q   <= press_nxt;
            long_q    <= long_nxt;
            release_q <= release_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        db_cnt_nxt    = db_cnt;
        hold_cnt_nxt  = hold_cnt;
        long_flag_nxt = long_flag;
        level_nxt     = level_q;
        press_nxt     = 1'b0;
        long_nxt      = 1'b0;
        release_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nxt  = DB_PRESS;
                    db_cnt_nxt = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt     = PRESSED;
                    level_nxt     = 1'b1;
                    press_nxt     = 1'b1;
                    hold_cnt_nxt  = '0;
                    long_flag_nxt = 1'b0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                // hold_cnt is left untouched on the way to DB_RELEASE so a
                // rejected release glitch resumes the hold where it stopped.
                if (!btn_sync) begin
                    state_nxt  = DB_RELEASE;
                    db_cnt_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt     = LONG_HELD;
                    long_nxt      = 1'b1;
                    long_flag_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (!btn_sync) begin
                    state_nxt  = DB_RELEASE;
                    db_cnt_nxt = '0;
                end
            end
            DB_RELEASE: begin
                // long_flag remembers which held state to go back to, so a
                // glitch after the long pulse cannot re-arm btn_long.
                if (btn_sync) begin
                    state_nxt = long_flag ? LONG_HELD : PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- switch debounce ----------------
    // A change is accepted once the synchronised value has differed from the
    // output and held the same value for SW_STABLE_CYCLES consecutive cycles.
    // Comparing the whole freq vector against its previous value means a
    // skewed multi-bit change restarts the count until every bit has settled.
    logic [1:0]      freq_prev, freq_q;
    logic [SW_W-1:0] freq_cnt;
    logic            dir_prev, dir_q;
    logic [SW_W-1:0] dir_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_prev <= 2'b00;
            freq_cnt  <= '0;
            freq_q    <= 2'b00;
        end else begin
            freq_prev <= freq_sync;
            if (freq_sync == freq_q || freq_sync != freq_prev) begin
                freq_cnt <= '0;
            end else if (freq_cnt == SW_LAST) begin
                freq_q   <= freq_sync;
                freq_cnt <= '0;
            end else begin
                freq_cnt <= freq_cnt + SW_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_prev <= 1'b0;
            dir_cnt  <= '0;
            dir_q    <= 1'b0;
        end else begin
            dir_prev <= dir_sync;
            if (dir_sync == dir_q || dir_sync != dir_prev) begin
                dir_cnt <= '0;
            end else if (dir_cnt == SW_LAST) begin
                dir_q   <= dir_sync;
                dir_cnt <= '0;
            end else begin
                dir_cnt <= dir_cnt + SW_W'(1);
            end
        end
    end

    assign io.btn_level   = level_q;
    assign io.btn_press   = press_q;
    assign io.btn_long    = long_q;
    assign io.btn_release = release_q;
    assign io.freq_set    = freq_q;
    assign io.dir_set     = dir_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Purpose: self-checking bench for input_conditioner with a run-length based reference model.
// Latency: model predicts registered outputs for every clock edge.
// Backpressure: none; stimulus is driven on the falling edge, outputs compared on the falling edge.
module tb_input_conditioner;
    localparam int D = 4;
    localparam int L = 16;
    localparam int S = 4;

    logic clk;
    logic rst;

    input_conditioner_if ifc ();

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .SW_STABLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // The conditioner sees, at edge k, the raw value sampled at edge k-2,
    // forced to 0 if reset was sampled at k-1 or k-2.  The button is then
    // described by run lengths: a press is a run of D+1 ones while released,
    // a release a run of D+1 zeros while pressed, and the long pulse comes
    // on the L-th edge (after the press) that sees 1 on two consecutive edges.
    bit         b_d1, b_d2, r_d1, r_d2, dr_d1, dr_d2;
    logic [1:0] f_d1, f_d2;
    int         run1, run0, pairs;
    bit         s_prev, fired;
    logic [1:0] f_prev; int f_run;
    bit         d_prev; int d_run;

    bit         e_level, e_press, e_long, e_rel, e_dir;
    logic [1:0] e_freq;

    always @(posedge clk) begin
        bit         s, dc;
        logic [1:0] fc;
        cyc++;
        s  = (r_d1 || r_d2) ? 1'b0  : b_d2;
        fc = (r_d1 || r_d2) ? 2'b00 : f_d2;
        dc = (r_d1 || r_d2) ? 1'b0  : dr_d2;
        e_press = 0; e_long = 0; e_rel = 0;
        if (rst) begin
            e_level = 0; e_freq = 0; e_dir = 0;
            run1 = 0; run0 = 0; pairs = 0; s_prev = 0; fired = 0;
            f_prev = 0; f_run = 0; d_prev = 0; d_run = 0;
        end else begin
            if (s) begin run1++; run0 = 0; end
            else   begin run0++; run1 = 0; end
            if (!e_level) begin
                if (run1 == D + 1) begin
                    e_level = 1; e_press = 1; pairs = 0; fired = 0;
                end
            end else if (run0 == D + 1) begin
                e_level = 0; e_rel = 1;
            end else if (!fired && s && s_prev) begin
                pairs++;
                if (pairs == L) begin e_long = 1; fired = 1; end
            end
            s_prev = s;

            if (fc == f_prev) f_run++; else f_run = 1;
            f_prev = fc;
            if (f_run >= S + 1 && fc != e_freq) e_freq = fc;

            if (dc == d_prev) d_run++; else d_run = 1;
            d_prev = dc;
            if (d_run >= S + 1 && dc != e_dir) e_dir = dc;
        end
        b_d2 = b_d1;  b_d1 = ifc.button;
        f_d2 = f_d1;  f_d1 = ifc.freq_set_raw;
        dr_d2 = dr_d1; dr_d1 = ifc.dir_set_raw;
        r_d2 = r_d1;  r_d1 = rst;
    end

    // ---------------- compare process + event log ----------------
    int         n_press = 0, n_long = 0, n_rel = 0, n_freq = 0, n_dir = 0;
    int         press_edge = -1, long_edge = -1, rel_edge = -1, freq_edge = -1;
    logic [1:0] last_freq = 2'b00;
    logic       last_dir  = 1'b0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("btn_level",   ifc.btn_level,   e_level);
            chk("btn_press",   ifc.btn_press,   e_press);
            chk("btn_long",    ifc.btn_long,    e_long);
            chk("btn_release", ifc.btn_release, e_rel);
            chk("freq_set",    ifc.freq_set,    e_freq);
            chk("dir_set",     ifc.dir_set,     e_dir);
            if (ifc.btn_press)   begin n_press++; press_edge = cyc; end
            if (ifc.btn_long)    begin n_long++;  long_edge  = cyc; end
            if (ifc.btn_release) begin n_rel++;   rel_edge   = cyc; end
            if (ifc.freq_set !== last_freq) begin n_freq++; freq_edge = cyc; end
            if (ifc.dir_set  !== last_dir)  n_dir++;
            last_freq = ifc.freq_set;
            last_dir  = ifc.dir_set;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   ifc.btn_level,   0);
        chk({tag, "_press"},   ifc.btn_press,   0);
        chk({tag, "_long"},    ifc.btn_long,    0);
        chk({tag, "_release"}, ifc.btn_release, 0);
        chk({tag, "_freq"},    ifc.freq_set,    0);
        chk({tag, "_dir"},     ifc.dir_set,     0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n, r, p0, l0, r0, f0, d0;
        rst = 1'b1;
        ifc.button = 1'b0;
        ifc.freq_set_raw = 2'b00;
        ifc.dir_set_raw = 1'b0;
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(5);

        // Clean press: high for 12 sampled edges starting at edge n.
        p0 = n_press; l0 = n_long; r0 = n_rel;
        n = cyc + 1;
        ifc.button = 1'b1; tick(12);
        ifc.button = 1'b0; tick(20);
        chk("clean_press_edge", press_edge, n + 6);
        chk("clean_rel_edge",   rel_edge,   n + 18);
        chk("clean_press_cnt",  n_press - p0, 1);
        chk("clean_long_cnt",   n_long - l0,  0);
        chk("clean_rel_cnt",    n_rel - r0,   1);

        // Press bounce: 3 high / 1 low never completes a debounce window.
        p0 = n_press; r0 = n_rel;
        for (int i = 0; i < 10; i++) begin
            ifc.button = 1'b1; tick(3);
            ifc.button = 1'b0; tick(1);
        end
        tick(10);
        chk("bounce_press_cnt", n_press - p0, 0);
        chk("bounce_rel_cnt",   n_rel - r0,   0);
        chk("bounce_level",     ifc.btn_level, 0);

        // Long hold: 40 cycles.
        p0 = n_press; l0 = n_long; r0 = n_rel;
        n = cyc + 1;
        ifc.button = 1'b1; tick(40);
        ifc.button = 1'b0; tick(15);
        chk("long_press_edge", press_edge, n + 6);
        chk("long_long_edge",  long_edge,  n + 22);
        chk("long_rel_edge",   rel_edge,   n + 46);
        chk("long_press_cnt",  n_press - p0, 1);
        chk("long_long_cnt",   n_long - l0,  1);
        chk("long_rel_cnt",    n_rel - r0,   1);

        // Release glitch: 2-cycle drop while PRESSED freezes the hold count.
        p0 = n_press; l0 = n_long; r0 = n_rel;
        n = cyc + 1;
        ifc.button = 1'b1; tick(14);
        ifc.button = 1'b0; tick(2);
        ifc.button = 1'b1; tick(10);
        chk("glitch_level_held", ifc.btn_level, 1);
        chk("glitch_no_release", n_rel - r0, 0);
        tick(20);
        ifc.button = 1'b0; tick(15);
        chk("glitch_press_edge", press_edge, n + 6);
        chk("glitch_long_edge",  long_edge,  n + 25);
        chk("glitch_rel_edge",   rel_edge,   n + 52);
        chk("glitch_press_cnt",  n_press - p0, 1);
        chk("glitch_long_cnt",   n_long - l0,  1);
        chk("glitch_rel_cnt",    n_rel - r0,   1);

        // Switches: skewed freq change and a too-short dir pulse.
        f0 = n_freq; d0 = n_dir;
        n = cyc + 1;
        ifc.freq_set_raw = 2'b10; ifc.dir_set_raw = 1'b1; tick(2);
        ifc.freq_set_raw = 2'b00; tick(1);
        ifc.freq_set_raw = 2'b10; ifc.dir_set_raw = 1'b0; tick(12);
        chk("sw_freq_edge",  freq_edge, n + 9);
        chk("sw_freq_value", ifc.freq_set, 2);
        chk("sw_freq_cnt",   n_freq - f0, 1);
        chk("sw_dir_cnt",    n_dir - d0,  0);

        // Reset while LONG_HELD with the button held down.
        l0 = n_long;
        n = cyc + 1;
        ifc.button = 1'b1; tick(25);
        chk("rst_pre_long_cnt", n_long - l0, 1);
        chk("rst_pre_level",    ifc.btn_level, 1);
        p0 = n_press; l0 = n_long; r0 = n_rel;
        r = cyc + 1;
        rst = 1'b1; tick(1);
        chk_all_zero("midrst");
        rst = 1'b0;
        tick(10);
        chk("rst_repress_edge", press_edge, r + 7);
        chk("rst_repress_cnt",  n_press - p0, 1);
        chk("rst_no_release",   n_rel - r0,   0);
        ifc.button = 1'b0; tick(15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
